// File: rtl/xcorr_pkg.sv
// Shared definitions for the cross-correlation peak tracker: FSM state
// encoding, width helpers, and the saturation ceiling for |xcorr|.
package xcorr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Signed lag width: enough for -lagnum..+lagnum with margin for the sign.
    function automatic int lag_width(input int lagnum);
        return $clog2(2 * lagnum + 1) + 1;
    endfunction

    // Channel tag width; a single channel still gets one bit.
    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Largest magnitude representable in dw-1 unsigned bits: 2^(dw-1)-1.
    function automatic logic [63:0] sat_abs_max(input int dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/xcorr_abs_sat.sv
// Signed-to-magnitude conversion with saturation. The most negative input
// has no positive twin in DW bits, so it is clamped to 2^(DW-1)-1.
module xcorr_abs_sat
    import xcorr_pkg::*;
#(
    parameter int DW = 33
) (
    input  logic signed [DW-1:0] din,
    output logic        [DW-2:0] mag
);

    localparam logic [63:0]          SAT_MAX  = sat_abs_max(DW);
    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW - 1){1'b0}}};

    logic signed [DW-1:0] neg;

    assign neg = -din;

    // Pick the magnitude, clamping the one value whose negation overflows
    always_comb begin
        // NOTE: output gets a default before any branch so no latch is inferred.
        mag = din[DW-2:0];
        if (din == MOST_NEG) begin
            mag = SAT_MAX[DW-2:0];
        end else if (din[DW-1]) begin
            mag = neg[DW-2:0];
        end
    end

endmodule

// File: rtl/xcorr_peak_tracker.sv
// Per-channel lag-of-maximum search over an interleaved xcorr sweep.
// Samples arrive lag-major (lag ascending, channels 0..NCH-1 within a lag);
// at the end of a sweep all lags and peaks are published with res_valid.
// Optional feature macro: XCORR_PEAK_THRESH_EN adds a 'thresh' input that
// qualifies each channel's peak and zeroes the lag of unqualified channels.
module xcorr_peak_tracker
    import xcorr_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int LAGNUM = 10,
    parameter int DW     = 33
) (
    input  logic                                   clk_60MHz,
    input  logic                                   rst,
    input  logic                                   sweep_start,
    input  logic                                   xc_valid,
    output logic                                   xc_ready,
    input  logic [ch_width(NCH)-1:0]               xc_ch,
    input  logic signed [DW-1:0]                   xc_data,
`ifdef XCORR_PEAK_THRESH_EN
    input  logic [DW-2:0]                          thresh,
`endif
    output logic signed [NCH*lag_width(LAGNUM)-1:0] lag_out,
    output logic [NCH*(DW-1)-1:0]                  peak_out,
    output logic [NCH-1:0]                         peak_ok,
    output logic                                   res_valid,
    output logic                                   busy,
    output logic                                   seq_err
);

    localparam int LAGW = lag_width(LAGNUM);
    localparam int CHW  = ch_width(NCH);

    localparam logic signed [LAGW-1:0] LAG_MIN = LAGW'(-LAGNUM);
    localparam logic signed [LAGW-1:0] LAG_MAX = LAGW'(LAGNUM);
    localparam logic        [CHW-1:0]  CH_LAST = CHW'(NCH - 1);

    state_t                 state, state_nxt;
    logic signed [LAGW-1:0] lag_cnt;
    logic        [CHW-1:0]  ch_cnt;
    logic        [DW-2:0]   mag;
    logic                   accept;
    logic                   first_lag;
    logic                   last_xfer;
    logic        [NCH-1:0]  ok_nxt;

    logic        [DW-2:0]   max_r   [NCH];
    logic        [DW-2:0]   max_nxt [NCH];
    logic signed [LAGW-1:0] arg_r   [NCH];
    logic signed [LAGW-1:0] arg_nxt [NCH];

    xcorr_abs_sat #(.DW(DW)) u_abs (
        .din (xc_data),
        .mag (mag)
    );

    // A restart request beats a coincident sample: that sample is dropped.
    assign accept    = (state == SWEEP) && xc_valid && !sweep_start;
    assign first_lag = (lag_cnt == LAG_MIN);
    assign last_xfer = (lag_cnt == LAG_MAX) && (ch_cnt == CH_LAST);

    // State register
    always_ff @(posedge clk_60MHz or posedge rst) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and handshake/status outputs
    always_comb begin
        state_nxt = state;
        xc_ready  = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (sweep_start) state_nxt = SWEEP;
            end
            SWEEP: begin
                xc_ready = 1'b1;
                busy     = 1'b1;
                if (sweep_start)              state_nxt = SWEEP;
                else if (accept && last_xfer) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                state_nxt = sweep_start ? SWEEP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fold the current sample into its channel's running max; the first lag
    // loads unconditionally and later lags win only when strictly larger
    always_comb begin
        max_nxt = max_r;
        arg_nxt = arg_r;
        if (accept && (first_lag || (mag > max_r[ch_cnt]))) begin
            max_nxt[ch_cnt] = mag;
            arg_nxt[ch_cnt] = lag_cnt;
        end
    end

    // Peak qualification applied when results are published
    always_comb begin
`ifdef XCORR_PEAK_THRESH_EN
        ok_nxt = '0;
        for (int c = 0; c < NCH; c++) begin
            ok_nxt[c] = (max_nxt[c] >= thresh);
        end
`else
        ok_nxt = '1;
`endif
    end

    // Tracker storage
    always_ff @(posedge clk_60MHz) begin
        // NOTE: no reset on the tracker array; the first lag of every sweep
        // overwrites each entry before it can influence a published result.
        max_r <= max_nxt;
        arg_r <= arg_nxt;
    end

    // Sweep counters, sticky sequence error and published result registers
    always_ff @(posedge clk_60MHz or posedge rst) begin
        if (rst) begin
            lag_cnt  <= LAG_MIN;
            ch_cnt   <= '0;
            seq_err  <= 1'b0;
            lag_out  <= '0;
            peak_out <= '0;
            peak_ok  <= '0;
        end else if (sweep_start) begin
            lag_cnt <= LAG_MIN;
            ch_cnt  <= '0;
            seq_err <= 1'b0;
        end else if (accept) begin
            if (xc_ch != ch_cnt) seq_err <= 1'b1;
            if (ch_cnt == CH_LAST) begin
                ch_cnt  <= '0;
                lag_cnt <= lag_cnt + LAGW'(1);
            end else begin
                ch_cnt  <= ch_cnt + CHW'(1);
            end
            // The last channel's final update is taken from max_nxt so the
            // results land together with the DONE state.
            if (last_xfer) begin
                for (int c = 0; c < NCH; c++) begin
                    peak_out[c*(DW-1) +: DW-1] <= max_nxt[c];
                    lag_out[c*LAGW +: LAGW]    <= ok_nxt[c] ? arg_nxt[c] : '0;
                end
                peak_ok <= ok_nxt;
            end
        end
    end

endmodule
